dpe_sequencer: RTL

DPE_SEQUENCER -- requirements
Module: dpe_sequencer

---
 rtl/dpe_pkg.sv | 21 ++
 rtl/dpe_sequencer_if.sv | 40 ++++
 rtl/updown_counter.sv | 38 +++
 rtl/dpe_sequencer.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/dpe_pkg.sv
// Shared types and sizing helpers for the DPE sequencer.
package dpe_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCompute,
        StDrain
    } seq_state_e;

    // DPE pipeline depth: fixed front end plus one cycle per 4-lane group.
    function automatic int unsigned dpe_lat_calc(input int unsigned lanes);
        return 4 + lanes / 4;
    endfunction

    // Bits needed to represent every value in 0..max_val.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val == 0) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dpe_sequencer_if.sv
// Job, weight, activation, DPE and credit signals of the DPE sequencer.
interface dpe_sequencer_if #(
    parameter int unsigned IDATAW = 8,
    parameter int unsigned LANES  = 164
);
    localparam int unsigned DW = LANES * IDATAW;

    logic          i_cfg_valid;
    logic          o_cfg_ready;
    logic [15:0]   i_cfg_nvec;
    logic [DW-1:0] i_w_data;
    logic          i_w_valid;
    logic          o_w_ready;
    logic [DW-1:0] i_a_data;
    logic          i_a_valid;
    logic          o_a_ready;
    logic [DW-1:0] o_dpe_data;
    logic          o_dpe_valid;
    logic          o_dpe_load;
    logic          i_dpe_ovalid;
    logic          i_credit_ret;
    logic          o_busy;
    logic          o_done;
    logic          o_err;

    modport slave (
        input  i_cfg_valid, i_cfg_nvec, i_w_data, i_w_valid, i_a_data, i_a_valid,
               i_dpe_ovalid, i_credit_ret,
        output o_cfg_ready, o_w_ready, o_a_ready, o_dpe_data, o_dpe_valid, o_dpe_load,
               o_busy, o_done, o_err
    );

    modport master (
        output i_cfg_valid, i_cfg_nvec, i_w_data, i_w_valid, i_a_data, i_a_valid,
               i_dpe_ovalid, i_credit_ret,
        input  o_cfg_ready, o_w_ready, o_a_ready, o_dpe_data, o_dpe_valid, o_dpe_load,
               o_busy, o_done, o_err
    );

endinterface

// File: rtl/updown_counter.sv
// Saturating up/down counter; an overflow or underflow attempt holds the
// value and raises err for that cycle.
module updown_counter #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned MAX   = 15,
    parameter int unsigned INIT  = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] count,
    output logic             err
);
    logic [WIDTH-1:0] count_q, count_d;

    // Next value: simultaneous inc and dec cancel out.
    always_comb begin
        count_d = count_q;
        err     = 1'b0;
        if (inc && !dec) begin
            if (count_q == WIDTH'(MAX)) err = 1'b1;
            else                        count_d = count_q + WIDTH'(1);
        end else if (dec && !inc) begin
            if (count_q == '0) err = 1'b1;
            else               count_d = count_q - WIDTH'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) count_q <= WIDTH'(INIT);
        else     count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/dpe_sequencer.sv
// Sequences weight loads and activation issues into the DPE, throttled by
// output-FIFO credits, and reports job completion once results have drained.
module dpe_sequencer
    import dpe_pkg::*;
#(
    parameter int unsigned IDATAW  = 8,
    parameter int unsigned LANES   = 164,
    parameter int unsigned BATCH   = 1,
    parameter int unsigned DPE_LAT = dpe_lat_calc(LANES),
    parameter int unsigned CREDITS = 16
) (
    input logic            clk,
    input logic            rst,
    dpe_sequencer_if.slave bus
);
    localparam int unsigned DW = LANES * IDATAW;
    localparam int unsigned CW = cnt_width(CREDITS);
    localparam int unsigned IW = cnt_width(DPE_LAT + CREDITS);
    localparam int unsigned BW = cnt_width(BATCH);

    seq_state_e    state_q, state_d;
    logic [15:0]   nvec_q, nvec_d;
    logic [15:0]   issued_q, issued_d;
    logic [BW-1:0] wcnt_q, wcnt_d;
    logic          cfg_ready, w_ready, a_ready, drain_done;
    logic          w_hs, a_hs;
    logic [CW-1:0] credits;
    logic [IW-1:0] inflight;
    logic          credit_err, inflight_err;
    logic [DW-1:0] dpe_data_q;
    logic          dpe_valid_q, dpe_load_q, done_q, err_q;

    assign w_hs = w_ready & bus.i_w_valid;
    assign a_hs = a_ready & bus.i_a_valid;

    // Free slots in the output FIFO; credits survive across jobs.
    updown_counter #(
        .WIDTH (CW),
        .MAX   (CREDITS),
        .INIT  (CREDITS)
    ) u_credits (
        .clk   (clk),
        .rst   (rst),
        .inc   (bus.i_credit_ret),
        .dec   (a_hs),
        .count (credits),
        .err   (credit_err)
    );

    // Activations issued to the DPE whose results have not come back yet.
    updown_counter #(
        .WIDTH (IW),
        .MAX   (DPE_LAT + CREDITS),
        .INIT  (0)
    ) u_inflight (
        .clk   (clk),
        .rst   (rst),
        .inc   (a_hs),
        .dec   (bus.i_dpe_ovalid),
        .count (inflight),
        .err   (inflight_err)
    );

    // Next-state and handshake readiness for the job FSM.
    always_comb begin
        state_d    = state_q;
        nvec_d     = nvec_q;
        issued_d   = issued_q;
        wcnt_d     = wcnt_q;
        cfg_ready  = 1'b0;
        w_ready    = 1'b0;
        a_ready    = 1'b0;
        drain_done = 1'b0;
        unique case (state_q)
            StIdle: begin
                cfg_ready = 1'b1;
                if (bus.i_cfg_valid) begin
                    nvec_d   = bus.i_cfg_nvec;
                    issued_d = '0;
                    wcnt_d   = '0;
                    state_d  = StLoad;
                end
            end
            StLoad: begin
                w_ready = 1'b1;
                if (bus.i_w_valid) begin
                    wcnt_d = wcnt_q + BW'(1);
                    if (wcnt_q == BW'(BATCH - 1)) begin
                        state_d = (nvec_q == '0) ? StDrain : StCompute;
                    end
                end
            end
            StCompute: begin
                a_ready = (credits != '0) && (issued_q < nvec_q);
                if (a_ready && bus.i_a_valid) begin
                    issued_d = issued_q + 16'd1;
                    if (issued_d == nvec_q) state_d = StDrain;
                end
            end
            StDrain: begin
                if (inflight == '0) begin
                    drain_done = 1'b1;
                    state_d    = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM, job bookkeeping and the registered DPE-facing outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            nvec_q      <= '0;
            issued_q    <= '0;
            wcnt_q      <= '0;
            dpe_data_q  <= '0;
            dpe_valid_q <= 1'b0;
            dpe_load_q  <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            nvec_q      <= nvec_d;
            issued_q    <= issued_d;
            wcnt_q      <= wcnt_d;
            dpe_valid_q <= w_hs | a_hs;
            dpe_load_q  <= w_hs;
            if (w_hs)      dpe_data_q <= bus.i_w_data;
            else if (a_hs) dpe_data_q <= bus.i_a_data;
            done_q      <= drain_done;
            err_q       <= err_q | credit_err | inflight_err;
        end
    end

    assign bus.o_cfg_ready = cfg_ready;
    assign bus.o_w_ready   = w_ready;
    assign bus.o_a_ready   = a_ready;
    assign bus.o_dpe_data  = dpe_data_q;
    assign bus.o_dpe_valid = dpe_valid_q;
    assign bus.o_dpe_load  = dpe_load_q;
    assign bus.o_busy      = (state_q != StIdle);
    assign bus.o_done      = done_q;
    assign bus.o_err       = err_q;

endmodule
